// File: rtl/mpu_operand_loader.sv
// Streaming 5x5 operand loader: collects A then B row-major over valid/ready and holds both until acked.
// Optional MPU_LOADER_SIZE_EN adds a size port selecting a 2..5 active dimension per operand pair.
module mpu_operand_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
`ifdef MPU_LOADER_SIZE_EN
  input  logic [2:0]   size,
`endif
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         operands_valid,
  input  logic         operands_ack,
  output logic [5:0]   load_index
);

  localparam logic [1:0] FILL_A = 2'd0;
  localparam logic [1:0] FILL_B = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  logic [1:0]   state_r, state_n;
  logic [2:0]   row_r, row_n, col_r, col_n;
  logic [5:0]   load_index_r, load_index_n;
  logic         operands_valid_r, operands_valid_n;
  logic [199:0] matrix_a_r, matrix_a_n, matrix_b_r, matrix_b_n;
  logic         accept_s, first_s, last_s;
  logic [2:0]   dim_s;
  logic [4:0]   pos_s;

`ifdef MPU_LOADER_SIZE_EN
  logic [2:0] dim_r;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    logic [2:0] r;
    if (s < 3'd2) begin
      r = 3'd2;
    end else if (s > 3'd5) begin
      r = 3'd5;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Keeps only the top-left d x d elements of a packed 5x5 matrix.
  function automatic logic [199:0] region_mask(input logic [2:0] d);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        if ((i < int'(d)) && (j < int'(d))) begin
          m[(i*5+j)*8 +: 8] = 8'hFF;
        end else begin
          m[(i*5+j)*8 +: 8] = 8'h00;
        end
      end
    end
    return m;
  endfunction
`endif

  assign in_ready       = (state_r != FULL) && !flush;
  assign accept_s       = in_valid && in_ready;
  assign first_s        = (row_r == 3'd0) && (col_r == 3'd0);
  assign pos_s          = (5'(row_r) * 5'd5) + 5'(col_r);
  assign last_s         = (row_r == (dim_s - 3'd1)) && (col_r == (dim_s - 3'd1));
  assign matrix_a       = matrix_a_r;
  assign matrix_b       = matrix_b_r;
  assign operands_valid = operands_valid_r;
  assign load_index     = load_index_r;

  // The first A byte of a pair uses the live size, since dim_r is only captured on that edge.
`ifdef MPU_LOADER_SIZE_EN
  assign dim_s = ((state_r == FILL_A) && first_s) ? clamp_size(size) : dim_r;
`else
  assign dim_s = 3'd5;
`endif

  // Next-state logic: fill walk, FULL hold/rearm, flush override.
  always_comb begin
    state_n          = state_r;
    row_n            = row_r;
    col_n            = col_r;
    load_index_n     = load_index_r;
    operands_valid_n = operands_valid_r;
    matrix_a_n       = matrix_a_r;
    matrix_b_n       = matrix_b_r;
    if (flush) begin
      state_n          = FILL_A;
      row_n            = 3'd0;
      col_n            = 3'd0;
      load_index_n     = 6'd0;
      operands_valid_n = 1'b0;
      matrix_a_n       = '0;
      matrix_b_n       = '0;
    end else begin
      case (state_r)
        FILL_A, FILL_B: begin
          if (accept_s) begin
            if (state_r == FILL_A) begin
`ifdef MPU_LOADER_SIZE_EN
              if (first_s) matrix_a_n = matrix_a_n & region_mask(dim_s);
              else         matrix_a_n = matrix_a_n;
`endif
              matrix_a_n[{pos_s, 3'b000} +: 8] = in_data;
            end else begin
`ifdef MPU_LOADER_SIZE_EN
              if (first_s) matrix_b_n = matrix_b_n & region_mask(dim_s);
              else         matrix_b_n = matrix_b_n;
`endif
              matrix_b_n[{pos_s, 3'b000} +: 8] = in_data;
            end
            load_index_n = load_index_r + 6'd1;
            if (last_s) begin
              row_n = 3'd0;
              col_n = 3'd0;
              if (state_r == FILL_A) begin
                state_n = FILL_B;
              end else begin
                state_n          = FULL;
                operands_valid_n = 1'b1;
              end
            end else if (col_r == (dim_s - 3'd1)) begin
              col_n = 3'd0;
              row_n = row_r + 3'd1;
            end else begin
              col_n = col_r + 3'd1;
            end
          end else begin
            state_n = state_r;
          end
        end
        FULL: begin
          if (operands_ack) begin
            state_n          = FILL_A;
            load_index_n     = 6'd0;
            operands_valid_n = 1'b0;
          end else begin
            state_n = FULL;
          end
        end
        default: begin
          state_n          = FILL_A;
          row_n            = 3'd0;
          col_n            = 3'd0;
          load_index_n     = 6'd0;
          operands_valid_n = 1'b0;
        end
      endcase
    end
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= FILL_A;
      row_r            <= 3'd0;
      col_r            <= 3'd0;
      load_index_r     <= 6'd0;
      operands_valid_r <= 1'b0;
      matrix_a_r       <= '0;
      matrix_b_r       <= '0;
    end else begin
      state_r          <= state_n;
      row_r            <= row_n;
      col_r            <= col_n;
      load_index_r     <= load_index_n;
      operands_valid_r <= operands_valid_n;
      matrix_a_r       <= matrix_a_n;
      matrix_b_r       <= matrix_b_n;
    end
  end

`ifdef MPU_LOADER_SIZE_EN
  // Active dimension captured with the first A byte and held for the whole pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_r <= 3'd5;
    end else if (accept_s && (state_r == FILL_A) && first_s) begin
      dim_r <= dim_s;
    end else begin
      dim_r <= dim_r;
    end
  end
`endif

endmodule

// File: tb/tb_mpu_operand_loader.sv
// Directed self-checking bench for mpu_operand_loader; size tests run only when MPU_LOADER_SIZE_EN is defined.
module tb_mpu_operand_loader;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [199:0] matrix_a, matrix_b;
  logic         operands_valid;
  logic         operands_ack;
  logic [5:0]   load_index;
`ifdef MPU_LOADER_SIZE_EN
  logic [2:0]   size;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  mpu_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
`ifdef MPU_LOADER_SIZE_EN
    .size(size),
`endif
    .matrix_a(matrix_a), .matrix_b(matrix_b), .operands_valid(operands_valid),
    .operands_ack(operands_ack), .load_index(load_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // Expected d x d row-major fill starting at base, zero elsewhere.
  function automatic logic [199:0] mk(input logic [7:0] base, input int d);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        m[(i*5+j)*8 +: 8] = base + 8'(i*d+j);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input logic [7:0] start, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = start + 8'(k);
      step();
      if (gaps && (k != n-1)) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic ack();
    operands_ack = 1'b1;
    step();
    operands_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0; operands_ack = 1'b0;
`ifdef MPU_LOADER_SIZE_EN
    size = 3'd5;
`endif
    #2;
    check("rst_valid", 200'(operands_valid), 200'(1'b0));
    check("rst_ready", 200'(in_ready), 200'(1'b1));
    check("rst_idx", 200'(load_index), 200'(6'd0));
    check("rst_a", matrix_a, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back fill of 1..50 with boundary probes.
    stream(8'd1, 25, 1'b0);
    check("idx_after_a", 200'(load_index), 200'(6'd25));
    stream(8'd26, 24, 1'b0);
    check("valid_after_49", 200'(operands_valid), 200'(1'b0));
    stream(8'd50, 1, 1'b0);
    check("valid_after_50", 200'(operands_valid), 200'(1'b1));
    check("full_a", matrix_a, mk(8'd1, 5));
    check("full_b", matrix_b, mk(8'd26, 5));
    check("full_a00", 200'(matrix_a[7:0]), 200'(8'd1));
    check("full_b44", 200'(matrix_b[199:192]), 200'(8'd50));
    check("full_ready", 200'(in_ready), 200'(1'b0));
    check("full_idx", 200'(load_index), 200'(6'd50));

    // Traffic in FULL is refused; ack rearms and keeps old contents.
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (10) step();
    in_valid = 1'b0;
    check("hold_a", matrix_a, mk(8'd1, 5));
    check("hold_b", matrix_b, mk(8'd26, 5));
    check("hold_valid", 200'(operands_valid), 200'(1'b1));
    ack();
    check("ack_ready", 200'(in_ready), 200'(1'b1));
    check("ack_valid", 200'(operands_valid), 200'(1'b0));
    check("ack_idx", 200'(load_index), 200'(6'd0));
    check("ack_keep_a", matrix_a, mk(8'd1, 5));

    // Flush mid-load drops the coincident byte and clears everything.
    stream(8'h40, 30, 1'b0);
    check("pre_flush_idx", 200'(load_index), 200'(6'd30));
    in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
    #1;
    check("flush_ready", 200'(in_ready), 200'(1'b0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idx", 200'(load_index), 200'(6'd0));
    check("flush_a", matrix_a, '0);
    check("flush_b", matrix_b, '0);
    stream(8'd1, 50, 1'b0);
    check("post_flush_valid", 200'(operands_valid), 200'(1'b1));
    check("post_flush_a", matrix_a, mk(8'd1, 5));
    check("post_flush_b", matrix_b, mk(8'd26, 5));

    // Flush wins over a simultaneous ack in FULL.
    flush = 1'b1; operands_ack = 1'b1;
    step();
    flush = 1'b0; operands_ack = 1'b0;
    check("flush_ack_valid", 200'(operands_valid), 200'(1'b0));
    check("flush_ack_a", matrix_a, '0);

    // Gapped stream 0x80..0xB1 yields the same layout.
    stream(8'h80, 50, 1'b1);
    check("gap_valid", 200'(operands_valid), 200'(1'b1));
    check("gap_a", matrix_a, mk(8'h80, 5));
    check("gap_b", matrix_b, mk(8'h99, 5));
    ack();

    // Asynchronous reset in FILL_B takes effect between clock edges.
    stream(8'd1, 30, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_idx", 200'(load_index), 200'(6'd0));
    check("arst_a", matrix_a, '0);
    check("arst_b", matrix_b, '0);
    check("arst_ready", 200'(in_ready), 200'(1'b1));
    step();
    rst_n = 1'b1;
    stream(8'd1, 49, 1'b0);
    check("arst_no_partial", 200'(operands_valid), 200'(1'b0));
    stream(8'd50, 1, 1'b0);
    check("arst_refill_b", matrix_b, mk(8'd26, 5));
    ack();

`ifdef MPU_LOADER_SIZE_EN
    // Reduced dimension: 3x3 per matrix, outer elements zeroed.
    size = 3'd3;
    stream(8'd1, 18, 1'b0);
    check("sz3_valid", 200'(operands_valid), 200'(1'b1));
    check("sz3_idx", 200'(load_index), 200'(6'd18));
    check("sz3_a", matrix_a, mk(8'd1, 3));
    check("sz3_b", matrix_b, mk(8'd10, 3));
    ack();
    size = 3'd7;
    stream(8'd1, 50, 1'b0);
    check("sz7_valid", 200'(operands_valid), 200'(1'b1));
    check("sz7_a", matrix_a, mk(8'd1, 5));
    check("sz7_b", matrix_b, mk(8'd26, 5));
    ack();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
